// File: rtl/mrd_bank_sched.sv
// Bank scheduler for the mixed-radix DFT datapath.
// Moves NUM_BANKS memory banks through FREE -> FILL -> WAIT_CALC -> CALC ->
// WAIT_DRAIN -> DRAIN -> FREE with three round-robin pointers (write, calc,
// read). Because every pointer advances in the same ring order, frames leave
// in exactly the order they arrived.
// Start pulses and switch selects are decoded from registered state only, so
// a pulse is seen in the cycle after its bank reaches the waiting state, and
// the bank leaves that state on the same edge that ends the pulse.
module mrd_bank_sched #(
    parameter int NUM_BANKS = 2,
    parameter int BW        = $clog2(NUM_BANKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sink_valid,
    input  logic          sink_sop,
    input  logic          sink_eop,
    output logic          sink_ready,
    output logic [BW-1:0] sw_in,
    output logic          calc_start,
    output logic [BW-1:0] calc_bank,
    input  logic          calc_done,
    output logic          drain_start,
    output logic [BW-1:0] sw_out,
    input  logic          source_valid,
    input  logic          source_ready,
    input  logic          source_eop,
    output logic [BW:0]   occupancy,
    output logic [2:0]    err_pulse
);

    typedef enum logic [2:0] {
        FREE       = 3'd0,
        FILL       = 3'd1,
        WAIT_CALC  = 3'd2,
        CALC       = 3'd3,
        WAIT_DRAIN = 3'd4,
        DRAIN      = 3'd5
    } bank_state_t;

    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    bank_state_t   state_q [NUM_BANKS];
    bank_state_t   state_d [NUM_BANKS];
    logic [BW-1:0] wr_ptr_q, wr_ptr_d;
    logic [BW-1:0] calc_ptr_q, calc_ptr_d;
    logic [BW-1:0] rd_ptr_q, rd_ptr_d;
    logic [BW:0]   occupancy_q, occupancy_d;
    logic [2:0]    err_q, err_d;

    logic calc_busy;
    logic drain_busy;
    logic accept;
    logic drain_end;

    // Ring increment: pointers wrap at NUM_BANKS, which need not be a power of two.
    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == LAST_BANK) ? '0 : p + BW'(1);
    endfunction

    // Detect whether the single compute slot and the single drain slot are taken.
    always_comb begin
        calc_busy  = 1'b0;
        drain_busy = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (state_q[i] == CALC)  calc_busy  = 1'b1;
            if (state_q[i] == DRAIN) drain_busy = 1'b1;
        end
    end

    // Handshake and start decode, all from registered state (no input feedthrough).
    always_comb begin
        sink_ready  = (state_q[wr_ptr_q] == FREE) || (state_q[wr_ptr_q] == FILL);
        accept      = sink_valid && sink_ready;
        calc_start  = (state_q[calc_ptr_q] == WAIT_CALC) && !calc_busy;
        drain_start = (state_q[rd_ptr_q] == WAIT_DRAIN) && !drain_busy;
        drain_end   = source_valid && source_ready && source_eop && drain_busy;
    end

    // Next bank states, pointers, occupancy and error pulses. The fill, calc and
    // drain updates touch banks in disjoint states, so they never collide.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        calc_ptr_d  = calc_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = 3'b000;
        occupancy_d = '0;

        if (accept) begin
            case (state_q[wr_ptr_q])
                FREE: begin
                    if (!sink_sop) begin
                        err_d[0] = 1'b1;
                    end else if (sink_eop) begin
                        state_d[wr_ptr_q] = WAIT_CALC;
                        wr_ptr_d          = ptr_inc(wr_ptr_q);
                    end else begin
                        state_d[wr_ptr_q] = FILL;
                    end
                end
                FILL: begin
                    // A repeated sop restarts the fill in place; the bank stays in FILL.
                    if (sink_sop) err_d[1] = 1'b1;
                    if (sink_eop) begin
                        state_d[wr_ptr_q] = WAIT_CALC;
                        wr_ptr_d          = ptr_inc(wr_ptr_q);
                    end
                end
                default: ;
            endcase
        end

        if (calc_start) state_d[calc_ptr_q] = CALC;

        // The CALC bank is always the one at calc_ptr; a done pulse coinciding
        // with calc_start finds no active calc and is rejected.
        if (calc_done) begin
            if (calc_busy) begin
                state_d[calc_ptr_q] = WAIT_DRAIN;
                calc_ptr_d          = ptr_inc(calc_ptr_q);
            end else begin
                err_d[2] = 1'b1;
            end
        end

        if (drain_start) state_d[rd_ptr_q] = DRAIN;

        if (drain_end) begin
            state_d[rd_ptr_q] = FREE;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end

        for (int i = 0; i < NUM_BANKS; i++) begin
            if (state_d[i] != FREE) occupancy_d = occupancy_d + (BW+1)'(1);
        end
    end

    // State registers; reset discards every bank and in-flight frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANKS; i++) state_q[i] <= FREE;
            wr_ptr_q    <= '0;
            calc_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            occupancy_q <= '0;
            err_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            calc_ptr_q  <= calc_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occupancy_q <= occupancy_d;
            err_q       <= err_d;
        end
    end

    assign sw_in     = wr_ptr_q;
    assign calc_bank = calc_ptr_q;
    assign sw_out    = rd_ptr_q;
    assign occupancy = occupancy_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_mrd_bank_sched.sv
// Bench for mrd_bank_sched: a 2-bank and a 3-bank instance share one stimulus
// stream. A frame-counting reference model predicts every output each cycle;
// directed sequences pin selected cycles with hand-computed values.
module tb_mrd_bank_sched;

    logic clk;
    logic rst;
    logic sink_valid, sink_sop, sink_eop;
    logic calc_done;
    logic source_valid, source_ready, source_eop;

    logic       u2_sink_ready, u2_calc_start, u2_drain_start;
    logic [0:0] u2_sw_in, u2_calc_bank, u2_sw_out;
    logic [1:0] u2_occ;
    logic [2:0] u2_err;

    logic       u3_sink_ready, u3_calc_start, u3_drain_start;
    logic [1:0] u3_sw_in, u3_calc_bank, u3_sw_out;
    logic [2:0] u3_occ;
    logic [2:0] u3_err;

    mrd_bank_sched #(.NUM_BANKS(2)) u2 (
        .clk(clk), .rst(rst),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_ready(u2_sink_ready), .sw_in(u2_sw_in),
        .calc_start(u2_calc_start), .calc_bank(u2_calc_bank), .calc_done(calc_done),
        .drain_start(u2_drain_start), .sw_out(u2_sw_out),
        .source_valid(source_valid), .source_ready(source_ready), .source_eop(source_eop),
        .occupancy(u2_occ), .err_pulse(u2_err)
    );

    mrd_bank_sched #(.NUM_BANKS(3)) u3 (
        .clk(clk), .rst(rst),
        .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
        .sink_ready(u3_sink_ready), .sw_in(u3_sw_in),
        .calc_start(u3_calc_start), .calc_bank(u3_calc_bank), .calc_done(calc_done),
        .drain_start(u3_drain_start), .sw_out(u3_sw_out),
        .source_valid(source_valid), .source_ready(source_ready), .source_eop(source_eop),
        .occupancy(u3_occ), .err_pulse(u3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;
    bit rec_en   = 1'b0;
    int cb_q[$];
    int so_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: each instance is described by frame counters only.
    // nf = frames fully written, ncs/ncd = calcs started/done,
    // nds/nd = drains started/done, fill = a frame is being written.
    int m_nf[2], m_ncs[2], m_ncd[2], m_nds[2], m_nd[2];
    bit m_fill[2];
    bit [2:0] m_err[2];

    function automatic int nb(input int k);
        return (k == 0) ? 2 : 3;
    endfunction
    function automatic bit m_ready(input int k);
        return m_fill[k] || ((m_nf[k] - m_nd[k]) < nb(k));
    endfunction
    function automatic bit m_cstart(input int k);
        return ((m_nf[k] - m_ncs[k]) > 0) && (m_ncs[k] == m_ncd[k]);
    endfunction
    function automatic bit m_dstart(input int k);
        return ((m_ncd[k] - m_nds[k]) > 0) && (m_nds[k] == m_nd[k]);
    endfunction
    function automatic int m_occ(input int k);
        return m_nf[k] - m_nd[k] + int'(m_fill[k]);
    endfunction

    task automatic m_step(input int k);
        bit rdy, cs, ds, cact, dact;
        bit [2:0] e;
        if (rst) begin
            m_nf[k] = 0; m_ncs[k] = 0; m_ncd[k] = 0; m_nds[k] = 0; m_nd[k] = 0;
            m_fill[k] = 1'b0; m_err[k] = 3'b000;
            return;
        end
        rdy  = m_ready(k);
        cs   = m_cstart(k);
        ds   = m_dstart(k);
        cact = (m_ncs[k] != m_ncd[k]);
        dact = (m_nds[k] != m_nd[k]);
        e    = 3'b000;
        if (sink_valid && rdy) begin
            if (!m_fill[k]) begin
                if (!sink_sop)     e[0] = 1'b1;
                else if (sink_eop) m_nf[k]++;
                else               m_fill[k] = 1'b1;
            end else begin
                if (sink_sop) e[1] = 1'b1;
                if (sink_eop) begin
                    m_fill[k] = 1'b0;
                    m_nf[k]++;
                end
            end
        end
        if (cs) m_ncs[k]++;
        if (calc_done) begin
            if (cact) m_ncd[k]++;
            else      e[2] = 1'b1;
        end
        if (ds) m_nds[k]++;
        if (source_valid && source_ready && source_eop && dact) m_nd[k]++;
        m_err[k] = e;
    endtask

    always @(posedge clk) begin
        m_step(0);
        m_step(1);
    end

    task automatic cmp(input int k, input int sr, input int swi, input int cs, input int cb,
                       input int ds, input int swo, input int occ, input int err);
        string p;
        p = (k == 0) ? "n2" : "n3";
        chk({p, " sink_ready"},  sr,  int'(m_ready(k)));
        chk({p, " sw_in"},       swi, m_nf[k] % nb(k));
        chk({p, " calc_start"},  cs,  int'(m_cstart(k)));
        chk({p, " calc_bank"},   cb,  m_ncd[k] % nb(k));
        chk({p, " drain_start"}, ds,  int'(m_dstart(k)));
        chk({p, " sw_out"},      swo, m_nd[k] % nb(k));
        chk({p, " occupancy"},   occ, m_occ(k));
        chk({p, " err_pulse"},   err, int'(m_err[k]));
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            cmp(0, int'(u2_sink_ready), int'(u2_sw_in), int'(u2_calc_start), int'(u2_calc_bank),
                int'(u2_drain_start), int'(u2_sw_out), int'(u2_occ), int'(u2_err));
            cmp(1, int'(u3_sink_ready), int'(u3_sw_in), int'(u3_calc_start), int'(u3_calc_bank),
                int'(u3_drain_start), int'(u3_sw_out), int'(u3_occ), int'(u3_err));
        end
        if (rec_en && u3_calc_start)  cb_q.push_back(int'(u3_calc_bank));
        if (rec_en && u3_drain_start) so_q.push_back(int'(u3_sw_out));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sink_valid = 0; sink_sop = 0; sink_eop = 0; calc_done = 0;
        source_valid = 0; source_ready = 0; source_eop = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic beat(input bit s, input bit e);
        sink_valid = 1; sink_sop = s; sink_eop = e;
        tick();
        sink_valid = 0; sink_sop = 0; sink_eop = 0;
    endtask

    task automatic frame(input int len);
        for (int i = 0; i < len; i++) beat(i == 0, i == len - 1);
    endtask

    task automatic pulse_done();
        calc_done = 1;
        tick();
        calc_done = 0;
    endtask

    task automatic drain_eop();
        source_valid = 1; source_ready = 1; source_eop = 1;
        tick();
        source_valid = 0; source_ready = 0; source_eop = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stagger[3];
        stagger[0] = 5; stagger[1] = 2; stagger[2] = 7;
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        cmp_en = 1;

        // Reset state
        chk("rst n2 sink_ready", int'(u2_sink_ready), 1);
        chk("rst n2 sw_in", int'(u2_sw_in), 0);
        chk("rst n2 calc_start", int'(u2_calc_start), 0);
        chk("rst n2 drain_start", int'(u2_drain_start), 0);
        chk("rst n2 occupancy", int'(u2_occ), 0);
        chk("rst n2 err_pulse", int'(u2_err), 0);
        chk("rst n3 occupancy", int'(u3_occ), 0);

        // One 12-beat frame through a 2-bank scheduler
        frame(12);
        chk("f1 calc_start after eop", int'(u2_calc_start), 1);
        chk("f1 calc_bank", int'(u2_calc_bank), 0);
        chk("f1 sw_in advanced", int'(u2_sw_in), 1);
        chk("f1 occupancy", int'(u2_occ), 1);
        tick();
        chk("f1 calc_start one cycle", int'(u2_calc_start), 0);
        repeat (19) tick();
        pulse_done();
        chk("f1 drain_start after done", int'(u2_drain_start), 1);
        chk("f1 sw_out", int'(u2_sw_out), 0);
        chk("f1 calc_bank advanced", int'(u2_calc_bank), 1);
        tick();
        source_valid = 1; source_ready = 1;
        for (int i = 0; i < 12; i++) begin
            source_eop = (i == 11);
            tick();
        end
        idle();
        chk("f1 occupancy empty", int'(u2_occ), 0);
        chk("f1 sw_in after frame", int'(u2_sw_in), 1);
        chk("f1 n3 occupancy empty", int'(u3_occ), 0);

        // Back-to-back frames with calc_done withheld: 2-bank instance fills up
        do_reset(1);
        frame(4);
        frame(4);
        chk("full n2 sink_ready", int'(u2_sink_ready), 0);
        chk("full n2 occupancy", int'(u2_occ), 2);
        chk("full n3 sink_ready", int'(u3_sink_ready), 1);
        sink_valid = 1; sink_sop = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full n2 held not ready", int'(u2_sink_ready), 0);
            chk("full n2 held occupancy", int'(u2_occ), 2);
        end
        pulse_done();
        chk("full drain_start", int'(u2_drain_start), 1);
        chk("full next calc_start", int'(u2_calc_start), 1);
        chk("full next calc_bank", int'(u2_calc_bank), 1);
        tick();
        chk("full draining not ready", int'(u2_sink_ready), 0);
        drain_eop();
        chk("full freed ready", int'(u2_sink_ready), 1);
        chk("full freed occupancy", int'(u2_occ), 1);
        tick();
        chk("full frame3 accepted", int'(u2_occ), 2);
        chk("full frame3 in bank0", int'(u2_sw_in), 0);
        sink_valid = 0; sink_sop = 0;
        beat(0, 1);

        // Three banks, staggered calc_done, then wrap to bank 0
        do_reset(1);
        rec_en = 1;
        frame(3);
        frame(3);
        frame(3);
        for (int j = 0; j < 3; j++) begin
            repeat (stagger[j]) tick();
            pulse_done();
            tick();
            drain_eop();
        end
        rec_en = 0;
        chk("n3 calc seq length", cb_q.size(), 3);
        chk("n3 drain seq length", so_q.size(), 3);
        for (int i = 0; i < cb_q.size(); i++) chk("n3 calc_bank seq", cb_q[i], i);
        for (int i = 0; i < so_q.size(); i++) chk("n3 sw_out seq", so_q[i], i);
        chk("n3 drained occupancy", int'(u3_occ), 0);
        chk("n3 wrap sw_in", int'(u3_sw_in), 0);
        beat(1, 1);
        chk("n3 single-beat calc_start", int'(u3_calc_start), 1);
        chk("n3 single-beat calc_bank", int'(u3_calc_bank), 0);
        chk("n3 single-beat occupancy", int'(u3_occ), 1);
        tick(); tick();

        // Error injection
        do_reset(1);
        beat(0, 0);
        chk("err0 pulse", int'(u2_err), 1);
        chk("err0 beat dropped", int'(u2_occ), 0);
        tick();
        chk("err0 single cycle", int'(u2_err), 0);
        pulse_done();
        chk("err2 idle done", int'(u2_err), 4);
        tick();
        chk("err2 single cycle", int'(u2_err), 0);
        beat(1, 0);
        beat(1, 0);
        chk("err1 pulse", int'(u2_err), 2);
        chk("err1 still filling", int'(u2_sink_ready), 1);
        beat(0, 1);
        chk("err1 single cycle", int'(u2_err), 0);
        chk("same-cycle calc_start", int'(u2_calc_start), 1);
        pulse_done();
        chk("err2 same-cycle done", int'(u2_err), 4);
        chk("same-cycle bank kept", int'(u2_calc_bank), 0);
        chk("same-cycle occupancy", int'(u2_occ), 1);
        tick();
        chk("err2 same-cycle single", int'(u2_err), 0);

        // Reset mid-fill of bank 1 while bank 0 is in CALC
        beat(1, 0);
        beat(0, 0);
        chk("midrst occupancy before", int'(u2_occ), 2);
        do_reset(1);
        chk("midrst sink_ready", int'(u2_sink_ready), 1);
        chk("midrst sw_in", int'(u2_sw_in), 0);
        chk("midrst calc_bank", int'(u2_calc_bank), 0);
        chk("midrst sw_out", int'(u2_sw_out), 0);
        chk("midrst calc_start", int'(u2_calc_start), 0);
        chk("midrst drain_start", int'(u2_drain_start), 0);
        chk("midrst occupancy", int'(u2_occ), 0);
        chk("midrst err_pulse", int'(u2_err), 0);
        beat(1, 1);
        chk("midrst new frame calc_start", int'(u2_calc_start), 1);
        chk("midrst new frame calc_bank", int'(u2_calc_bank), 0);
        chk("midrst new frame sw_in", int'(u2_sw_in), 1);
        chk("midrst new frame occupancy", int'(u2_occ), 1);

        // Randomised traffic against the model
        do_reset(1);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            sink_valid   = ($urandom_range(0, 9) < 6);
            sink_sop     = ($urandom_range(0, 4) == 0);
            sink_eop     = ($urandom_range(0, 3) == 0);
            calc_done    = ($urandom_range(0, 7) == 0);
            source_valid = ($urandom_range(0, 9) < 7);
            source_ready = ($urandom_range(0, 9) < 7);
            source_eop   = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 599) == 0);
            tick();
        end
        idle();
        rst = 0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
